// File: rtl/icache_direct_if.sv
// Fetch-side and memory-controller-side signal bundle for icache_direct.
// The master modport is the environment (fetcher + controller); the slave modport is the cache.
interface icache_direct_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 2
);
  logic                      IFIC_en;
  logic [ADDR_WIDTH-1:0]     IFIC_addr;
  logic                      RoB_clr;
  logic                      ICIF_en;
  logic [31:0]               ICIF_data;
  logic                      ICMC_en;
  logic [ADDR_WIDTH-1:0]     ICMC_addr;
  logic                      MCIC_en;
  logic [32*BLOCK_SIZE-1:0]  MCIC_block;

  modport master (
    output IFIC_en, IFIC_addr, RoB_clr, MCIC_en, MCIC_block,
    input  ICIF_en, ICIF_data, ICMC_en, ICMC_addr
  );

  modport slave (
    input  IFIC_en, IFIC_addr, RoB_clr, MCIC_en, MCIC_block,
    output ICIF_en, ICIF_data, ICMC_en, ICMC_addr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, 256 lines of 2-word blocks, one outstanding block read.
// Define ICACHE_CNT_EN to build the 32-bit hit/miss counters; otherwise both read as 0.
module icache_direct #(
  parameter int BLOCK_WIDTH = 1,
  parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH,
  parameter int CACHE_WIDTH = 8,
  parameter int BLOCK_NUM   = 1 << CACHE_WIDTH,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic        Sys_clk,
  input  logic        Sys_rst_n,
  input  logic        Sys_rdy,
  icache_direct_if.slave bus,
  output logic [31:0] IC_hit_cnt,
  output logic [31:0] IC_miss_cnt
);
  localparam int OFF_W = BLOCK_WIDTH + 2;
  localparam int TAG_W = ADDR_WIDTH - CACHE_WIDTH - OFF_W;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                   state_reg;
  logic                     discard_reg;
  logic                     icif_en_reg;
  logic [31:0]              icif_data_reg;
  logic                     icmc_en_reg;
  logic [ADDR_WIDTH-1:0]    icmc_addr_reg;
  logic [CACHE_WIDTH-1:0]   lat_idx_reg;
  logic [TAG_W-1:0]         lat_tag_reg;
  logic [BLOCK_WIDTH-1:0]   lat_wsel_reg;
  logic [BLOCK_NUM-1:0]     valid_reg;

  logic [TAG_W-1:0]         tag_mem  [BLOCK_NUM];
  logic [32*BLOCK_SIZE-1:0] data_mem [BLOCK_NUM];

  logic [CACHE_WIDTH-1:0]   req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic [BLOCK_WIDTH-1:0]   req_wsel;
  logic                     hit;
  logic                     take;
  logic                     fill;
  logic [31:0]              hit_word;
  logic [31:0]              fill_word;
  logic                     unused_addr_bits;

  assign req_idx   = bus.IFIC_addr[OFF_W+CACHE_WIDTH-1:OFF_W];
  assign req_tag   = bus.IFIC_addr[ADDR_WIDTH-1:OFF_W+CACHE_WIDTH];
  assign req_wsel  = bus.IFIC_addr[OFF_W-1:2];
  assign unused_addr_bits = ^bus.IFIC_addr[1:0];

  assign hit       = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit_word  = data_mem[req_idx][{req_wsel, 5'b0} +: 32];
  assign fill_word = bus.MCIC_block[{lat_wsel_reg, 5'b0} +: 32];

  // A request is not sampled in the cycle its own response is visible.
  assign take = Sys_rdy && (state_reg == IDLE) && bus.IFIC_en && !bus.RoB_clr && !icif_en_reg;
  assign fill = Sys_rdy && (state_reg == WAIT_MEM) && bus.MCIC_en;

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      state_reg     <= IDLE;
      discard_reg   <= 1'b0;
      icif_en_reg   <= 1'b0;
      icif_data_reg <= '0;
      icmc_en_reg   <= 1'b0;
      icmc_addr_reg <= '0;
      lat_idx_reg   <= '0;
      lat_tag_reg   <= '0;
      lat_wsel_reg  <= '0;
      valid_reg     <= '0;
    end else if (Sys_rdy) begin
      icif_en_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (take) begin
            if (hit) begin
              icif_en_reg   <= 1'b1;
              icif_data_reg <= hit_word;
            end else begin
              lat_idx_reg   <= req_idx;
              lat_tag_reg   <= req_tag;
              lat_wsel_reg  <= req_wsel;
              icmc_en_reg   <= 1'b1;
              icmc_addr_reg <= {bus.IFIC_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
              state_reg     <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (bus.RoB_clr) discard_reg <= 1'b1;
          // The block read cannot be cancelled: the line is always filled, only the reply is dropped.
          if (bus.MCIC_en) begin
            valid_reg[lat_idx_reg] <= 1'b1;
            icmc_en_reg            <= 1'b0;
            if (!discard_reg && !bus.RoB_clr) begin
              icif_en_reg   <= 1'b1;
              icif_data_reg <= fill_word;
            end
            discard_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (fill) begin
      tag_mem[lat_idx_reg]  <= lat_tag_reg;
      data_mem[lat_idx_reg] <= bus.MCIC_block;
    end
  end

  assign bus.ICIF_en   = icif_en_reg;
  assign bus.ICIF_data = icif_data_reg;
  assign bus.ICMC_en   = icmc_en_reg;
  assign bus.ICMC_addr = icmc_addr_reg;

`ifdef ICACHE_CNT_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (take && hit)  hit_cnt_reg  <= hit_cnt_reg + 32'd1;
      if (take && !hit) miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  assign IC_hit_cnt  = hit_cnt_reg;
  assign IC_miss_cnt = miss_cnt_reg;
`else
  assign IC_hit_cnt  = '0;
  assign IC_miss_cnt = '0;
`endif
endmodule
